// File: rtl/fb_scanout_reader_if.sv
// SDRAM read-initiator bus for the frame-buffer scanout reader.
// master: the reader issuing rd/addr; slave: the SDRAM controller.
interface fb_scanout_reader_if;
  logic         sdram_rd;
  logic [21:0]  sdram_addr;
  logic         sdram_wait;
  logic         sdram_ac;
  logic [127:0] sdram_rddata;

  modport master (
    output sdram_rd,
    output sdram_addr,
    input  sdram_wait,
    input  sdram_ac,
    input  sdram_rddata
  );

  modport slave (
    input  sdram_rd,
    input  sdram_addr,
    output sdram_wait,
    output sdram_ac,
    output sdram_rddata
  );
endinterface

// File: rtl/fb_scanout_reader.sv
// Streams the displayed frame-buffer half from SDRAM into a word FIFO and unpacks pixels.
// Optional: define SCANOUT_UNDERRUN_COUNT_EN for a saturating underrun event counter.
module fb_scanout_reader #(
  parameter logic [21:0] FB_BASE0   = 22'h100000,
  parameter logic [21:0] FB_BASE1   = 22'h200000,
  parameter int          FB_WORDS   = 19200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_frame,
  input  logic                       frame_flip,
  fb_scanout_reader_if.master        sdram,
  output logic                       busy,
  output logic                       frame_done,
  input  logic                       pix_req,
  output logic [7:0]                 pix_data,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [14:0] LAST_C = 15'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, READ, CAPTURE, PAUSE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [21:0]   rd_addr_q, rd_addr_d;
  logic [14:0]   word_cnt_q, word_cnt_d;
  logic          restart_q, restart_d;
  logic          flip_q, flip_d;
  logic [127:0]  mem_q [FIFO_DEPTH];
  logic [127:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   cnt_after;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    pix_q, pix_d;
  logic          und_q, und_d;

  logic          latch, latch_flip, push, pop;
  logic          fifo_empty, fifo_full;
  logic [127:0]  head;

  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == DEPTH_C;
  assign head       = mem_q[rd_ptr_q];
  assign pop        = pix_req && !fifo_empty && idx_q == 4'hF;
  assign cnt_after  = count_q + (AW+1)'(1) - (AW+1)'(pop);

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    word_cnt_d = word_cnt_q;
    restart_d  = restart_q;
    flip_d     = flip_q;
    latch      = 1'b0;
    latch_flip = frame_flip;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (new_frame) begin
          latch   = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        latch = new_frame;
        if (!sdram.sdram_wait && !fifo_full) state_d = READ;
      end
      READ: begin
        if (new_frame) begin
          restart_d = 1'b1;
          flip_d    = frame_flip;
        end
        if (sdram.sdram_ac) state_d = CAPTURE;
      end
      CAPTURE: begin
        // A restart requested mid-access throws this word away.
        if (restart_q || new_frame) begin
          latch      = 1'b1;
          latch_flip = new_frame ? frame_flip : flip_q;
          state_d    = ARM;
        end else begin
          push       = 1'b1;
          rd_addr_d  = rd_addr_q + 22'd1;
          word_cnt_d = word_cnt_q + 15'd1;
          if (word_cnt_q == LAST_C)    state_d = DONE;
          else if (sdram.sdram_wait)   state_d = PAUSE;
          else if (cnt_after == DEPTH_C) state_d = ARM;
          else                         state_d = READ;
        end
      end
      PAUSE: begin
        latch = new_frame;
        if (!sdram.sdram_wait) state_d = ARM;
      end
      DONE: begin
        if (new_frame) begin
          latch   = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      rd_addr_d  = latch_flip ? FB_BASE0 : FB_BASE1;
      word_cnt_d = '0;
      restart_d  = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = sdram.sdram_rddata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    pix_d = pix_q;
    idx_d = idx_q;
    und_d = und_q;
    if (pix_req) begin
      if (!fifo_empty) begin
        pix_d = head[{idx_q, 3'b000} +: 8];
        idx_d = idx_q + 4'd1;
      end else begin
        pix_d = 8'h00;
        und_d = 1'b1;
      end
    end
    if (latch) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
      und_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      word_cnt_q <= '0;
      restart_q  <= 1'b0;
      flip_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      pix_q      <= '0;
      und_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      word_cnt_q <= word_cnt_d;
      restart_q  <= restart_d;
      flip_q     <= flip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      pix_q      <= pix_d;
      und_q      <= und_d;
      mem_q      <= mem_d;
    end
  end

  assign sdram.sdram_rd   = state_q == READ;
  assign sdram.sdram_addr = (state_q == READ) ? rd_addr_q : '0;
  assign busy       = state_q == READ || state_q == CAPTURE;
  assign frame_done = state_q == DONE;
  assign pix_data   = pix_q;
  assign underrun   = und_q;

`ifdef SCANOUT_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (pix_req && fifo_empty && ucnt_q != 16'hFFFF)
      ucnt_d = ucnt_q + 16'd1;
    if (latch) ucnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fb_scanout_reader.sv
// Scoreboard bench for fb_scanout_reader with a small SDRAM responder.
// FB_WORDS is shortened to one row so a whole frame fits in a short run.
module tb_fb_scanout_reader;
  localparam int WORDS = 40;
`ifdef SCANOUT_UNDERRUN_COUNT_EN
  localparam logic [15:0] EXP_UCNT = 16'd3;
`else
  localparam logic [15:0] EXP_UCNT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_frame = 1'b0;
  logic        frame_flip = 1'b0;
  logic        pix_req = 1'b0;
  logic        busy, frame_done, underrun;
  logic [7:0]  pix_data;
  logic [15:0] underrun_cnt;

  fb_scanout_reader_if sif();

  fb_scanout_reader #(.FB_WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .frame_flip   (frame_flip),
    .sdram        (sif),
    .busy         (busy),
    .frame_done   (frame_done),
    .pix_req      (pix_req),
    .pix_data     (pix_data),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;
  logic [21:0] last_acc = '0;
  logic [21:0] exp_addr [$];
  logic [7:0]  exp_pix [$];
  bit          rd_seen = 1'b0;
  logic [21:0] acc_addr = '0;

  function automatic logic [7:0] wbyte(logic [21:0] a, int i);
    return {a[3] ^ a[20], a[2:0], 4'(i)};
  endfunction

  function automatic logic [127:0] word_of(logic [21:0] a);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = wbyte(a, i);
    return w;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame(logic flip);
    frame_flip = flip;
    new_frame  = 1'b1;
    tick(1);
    new_frame  = 1'b0;
  endtask

  task automatic pix_pulses(int n);
    repeat (n) begin
      pix_req = 1'b1;
      tick(1);
      pix_req = 1'b0;
      tick(1);
    end
  endtask

  // kind 0: a READ cycle; kind 1: a CAPTURE cycle
  task automatic wait_for(int kind, string nm);
    bit hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      tick(1);
      hit = (kind == 0) ? sif.sdram_rd : (busy && !sif.sdram_rd);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting, got none expected event", nm);
    end
  endtask

  // SDRAM controller: ac one cycle after rd, data the cycle after ac
  initial begin
    sif.sdram_ac     = 1'b0;
    sif.sdram_rddata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sif.sdram_ac = 1'b0;
        rd_seen      = 1'b0;
      end else if (sif.sdram_ac) begin
        sif.sdram_ac     = 1'b0;
        sif.sdram_rddata = word_of(acc_addr);
        rd_seen          = 1'b0;
      end else if (sif.sdram_rd) begin
        if (rd_seen) begin
          sif.sdram_ac = 1'b1;
          acc_addr     = sif.sdram_addr;
        end else begin
          rd_seen = 1'b1;
        end
      end else begin
        rd_seen = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && sif.sdram_rd && sif.sdram_ac) begin
        n_acc++;
        last_acc = sif.sdram_addr;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL addr: got request %0h expected none", sif.sdram_addr);
        end else begin
          chk("addr", sif.sdram_addr, exp_addr.pop_front());
        end
      end
    end
  end

  initial begin
    logic pr;
    forever begin
      @(posedge clk);
      pr = pix_req;
      @(negedge clk);
      if (pr) begin
        if (exp_pix.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix: got %0h expected no pixel", pix_data);
        end else begin
          chk("pix", pix_data, exp_pix.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    sif.sdram_wait = 1'b0;
    tick(3);
    chk("rst_rd", sif.sdram_rd, 0);
    chk("rst_addr", sif.sdram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pix", pix_data, 0);
    chk("rst_und", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    reset = 1'b0;
    tick(2);

    // display buffer 1, no consumer: fills 8 words then stalls
    for (int k = 0; k < 8; k++) exp_addr.push_back(22'h200000 + 22'(k));
    pulse_frame(1'b0);
    tick(60);
    chk("fill_cnt", n_acc, 8);
    chk("fill_rd", sif.sdram_rd, 0);
    chk("fill_busy", busy, 0);
    chk("fill_done", frame_done, 0);

    // 16 single pulses: pixels 00..0F, then one refill read
    exp_addr.push_back(22'h200008);
    for (int i = 0; i < 16; i++) exp_pix.push_back(8'(i));
    pix_pulses(16);
    tick(20);
    chk("pop_refill", n_acc, 9);

    // 32 back-to-back requests: pixels 10..2F, two refills
    exp_addr.push_back(22'h200009);
    exp_addr.push_back(22'h20000A);
    for (int i = 0; i < 32; i++) exp_pix.push_back(8'(8'h10 + i));
    pix_req = 1'b1;
    tick(32);
    pix_req = 1'b0;
    tick(40);
    chk("burst_cnt", n_acc, 11);
    chk("burst_rd", sif.sdram_rd, 0);

    // flip to buffer 0 while controller waits: empty FIFO underruns
    sif.sdram_wait = 1'b1;
    pulse_frame(1'b1);
    chk("flip_und_clr", underrun, 0);
    for (int i = 0; i < 3; i++) exp_pix.push_back(8'h00);
    pix_pulses(3);
    chk("und_flag", underrun, 1);
    chk("und_cnt", underrun_cnt, EXP_UCNT);
    chk("wait_rd", sif.sdram_rd, 0);

    // whole short frame from buffer 0 with a 5-cycle pause after word 0
    for (int k = 0; k < WORDS; k++) exp_addr.push_back(22'h100000 + 22'(k));
    sif.sdram_wait = 1'b0;
    wait_for(1, "capture");
    sif.sdram_wait = 1'b1;
    chk("mid_done", frame_done, 0);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk("pause_rd", sif.sdram_rd, 0);
    end
    sif.sdram_wait = 1'b0;
    tick(30);
    for (int k = 0; k < WORDS; k++)
      for (int i = 0; i < 16; i++)
        exp_pix.push_back(wbyte(22'h100000 + 22'(k), i));
    pix_req = 1'b1;
    tick(WORDS * 16);
    pix_req = 1'b0;
    tick(20);
    chk("frame_done", frame_done, 1);
    chk("frame_cnt", n_acc, 11 + WORDS);
    chk("last_addr", last_acc, 22'h100027);
    chk("done_rd", sif.sdram_rd, 0);
    chk("done_ucnt", underrun_cnt, EXP_UCNT);
    chk("addr_left", exp_addr.size(), 0);
    chk("pix_left", exp_pix.size(), 0);

    // restart during a pending read: word dropped, refetch from new base
    exp_addr.push_back(22'h100000);
    pulse_frame(1'b1);
    chk("restart_done", frame_done, 0);
    chk("restart_und", underrun, 0);
    wait_for(0, "read");
    frame_flip = 1'b0;
    new_frame  = 1'b1;
    tick(1);
    new_frame  = 1'b0;
    chk("hold_rd", sif.sdram_rd, 1);
    for (int k = 0; k < 8; k++) exp_addr.push_back(22'h200000 + 22'(k));
    tick(60);
    chk("restart_cnt", n_acc, 11 + WORDS + 9);
    exp_pix.push_back(8'h00);
    exp_pix.push_back(8'h01);
    pix_pulses(2);

    // async reset while a read is outstanding
    pulse_frame(1'b0);
    wait_for(0, "read2");
    #1;
    reset = 1'b1;
    #1;
    chk("arst_rd", sif.sdram_rd, 0);
    chk("arst_addr", sif.sdram_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pix", pix_data, 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("idle_rd", sif.sdram_rd, 0);
    chk("idle_cnt", n_acc, 11 + WORDS + 9);
    chk("end_addr_left", exp_addr.size(), 0);
    chk("end_pix_left", exp_pix.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
Read-side counterpart of the background/lane draw path: streams the frame buffer half *not* being drawn from SDRAM to the display pixel pipe. It acts as an SDRAM read initiator on the shared rd/wait/ac handshake and fills a small 128-bit word FIFO. It unpacks each word into sixteen 8-bit pixels on request from the VGA timing logic. Frame buffer is 640x480 at 8 bpp, 40 words per row, contiguous.

Parameters:
FB_BASE0, 22'h100000, word base of frame buffer 0
FB_BASE1, 22'h200000, word base of frame buffer 1
FB_WORDS, 19200, words per frame (480 rows x 40)
FIFO_DEPTH, 8, word FIFO entries, power of 2, >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
new_frame  in  1  one-cycle pulse, start of frame scan
frame_flip  in  1  1: drawer writes buffer 1, so display buffer 0; 0: display buffer 1
sdram_wait  in  1  controller not ready for new access
sdram_ac  in  1  controller accepted current request
sdram_rddata  in  128  read data, valid cycle after sdram_ac
sdram_rd  out  1  read request
sdram_addr  out  22  word address
busy  out  1  SDRAM access in progress
frame_done  out  1  all FB_WORDS fetched for current frame
pix_req  in  1  consume one pixel
pix_data  out  8  pixel, valid cycle after pix_req
underrun  out  1  sticky: pix_req seen with no pixel available
underrun_cnt  out  16  see Optional Feature

Behaviour:
- Reset (async): state IDLE, sdram_rd=0, sdram_addr=0, busy=0, frame_done=0, pix_data=0, underrun=0, FIFO empty, word counter 0, pixel index 0.
- States: IDLE, ARM, READ, CAPTURE, PAUSE, DONE.
- IDLE: wait for new_frame. On new_frame: latch disp_base = frame_flip ? FB_BASE0 : FB_BASE1, set rd_addr=disp_base, word_cnt=0, flush FIFO, pixel index=0, clear underrun. Go to ARM.
- ARM: go to READ when ~sdram_wait and FIFO count < FIFO_DEPTH. Otherwise hold.
- READ: sdram_rd=1, sdram_addr=rd_addr, busy=1. Hold until sdram_ac, then go to CAPTURE.
- CAPTURE: busy=1. Push sdram_rddata into FIFO (room is guaranteed by the ARM check). rd_addr+=1, word_cnt+=1.
  - If word_cnt+1==FB_WORDS, go to DONE.
  - Else if sdram_wait, go to PAUSE.
  - Else if FIFO is full after the push, go to ARM.
  - Else go to READ.
- PAUSE: go to ARM when ~sdram_wait.
- DONE: frame_done=1. Leave on new_frame, performing the IDLE latch actions, and go to ARM.
- sdram_addr=0 in every state except READ.
- new_frame during READ/CAPTURE: set restart_pending. The current access completes normally, but its captured data is discarded. Then perform the latch actions and go to ARM.
- new_frame in ARM/PAUSE: latch immediately, stay in the same state.
- Pixel unpack:
  - pix_req with FIFO non-empty: pix_data <= head[8*idx+7 : 8*idx] next cycle, idx+=1 (4-bit wrap).
  - On idx 15 -> 0, pop the FIFO head.
  - pix_req with FIFO empty: pix_data <= 0, underrun <= 1, idx unchanged.
  - No pix_req: pix_data holds its value.
- Simultaneous push and pop of the same cycle are both honoured; count is unchanged.
- Address arithmetic is 22-bit unsigned. word_cnt is 15-bit.

Optional Feature:
SCANOUT_UNDERRUN_COUNT_EN
- Defined: underrun_cnt counts empty-FIFO pix_req cycles, saturates at 16'hFFFF, and clears on reset and on each frame latch.
- Undefined: underrun_cnt tied to 0, no counter logic. The sticky underrun flag is unaffected.

Test Plan:
- frame_flip=1, new_frame pulse, controller sets ac one cycle after rd -> first sdram_addr=22'h100000. Addresses increment by 1; after 19200 captures, frame_done=1, last address 22'h104AFF.
- frame_flip=0 -> first address 22'h200000. With no pix_req, exactly 8 reads are issued and the block stalls in ARM with sdram_rd=0.
- rddata=128'h0F0E...0100, 16 pix_req pulses -> pix_data 8'h00..8'h0F in order. FIFO count decrements by 1 after the 16th.
- sdram_wait=1 for 5 cycles during CAPTURE -> PAUSE, sdram_rd=0 for those cycles, then resumes at next address with no skip or duplicate.
- pix_req on empty FIFO 3 times -> pix_data=0, underrun=1, underrun_cnt=3 with macro defined, 0 without.
- new_frame while READ pending -> sdram_rd held until ac, captured word dropped, next request at new disp_base. Async reset mid-READ -> sdram_rd=0 immediately.
